// File: rtl/hazard_detection_unit_if.sv
// Hazard-unit pipeline signal bundle: ID/EX and IF/ID status in, pipeline enables/bubbles out.
interface hazard_detection_unit_if;
   logic        MemRead_IDEX;
   logic        RegWrite_IDEX;
   logic        FlagWrite_IDEX;
   logic [3:0]  DstReg1_in_from_IDEX;
   logic [3:0]  SrcReg1_in_from_IFID;
   logic [3:0]  SrcReg2_in_from_IFID;
   logic        UsesSrc1_IFID;
   logic        UsesSrc2_IFID;
   logic        MemWrite_IFID;
   logic        Branch_IFID;
   logic        BR_IFID;
   logic        branch_taken_ID;
   logic        mem_busy;
   logic        PC_write;
   logic        IFID_write;
   logic        IDEX_bubble;
   logic        IFID_flush;
   logic        pipe_hold;
   logic        MEMWB_bubble;
   logic [15:0] stall_cycles;

   modport master (
      output MemRead_IDEX, RegWrite_IDEX, FlagWrite_IDEX, DstReg1_in_from_IDEX,
             SrcReg1_in_from_IFID, SrcReg2_in_from_IFID, UsesSrc1_IFID, UsesSrc2_IFID,
             MemWrite_IFID, Branch_IFID, BR_IFID, branch_taken_ID, mem_busy,
      input  PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_hold, MEMWB_bubble,
             stall_cycles
   );

   modport slave (
      input  MemRead_IDEX, RegWrite_IDEX, FlagWrite_IDEX, DstReg1_in_from_IDEX,
             SrcReg1_in_from_IFID, SrcReg2_in_from_IFID, UsesSrc1_IFID, UsesSrc2_IFID,
             MemWrite_IFID, Branch_IFID, BR_IFID, branch_taken_ID, mem_busy,
      output PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_hold, MEMWB_bubble,
             stall_cycles
   );
endinterface

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use, BR-register and flag stalls, branch flush, memory-busy freeze.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
//
// state    | meaning
// RUN      | normal issue; hazards evaluated combinationally
// STALL    | extra stall cycles still owed (rem)
// MEM_WAIT | data memory busy; pipeline frozen, owed stalls parked in saved_rem
module hazard_detection_unit (
   input  logic                    clk,
   input  logic                    rst,
   hazard_detection_unit_if.slave  hz
);

   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

   state_t     state, state_nx;
   logic [1:0] rem, rem_nx;
   logic [1:0] saved_rem, saved_rem_nx;
   logic [1:0] eff_rem;
   logic [1:0] n_stall;
   logic       hit1, hit2, load_use, br_hz, flag_hz;

   assign hit1 = hz.UsesSrc1_IFID & (hz.DstReg1_in_from_IDEX == hz.SrcReg1_in_from_IFID)
                 & (|hz.DstReg1_in_from_IDEX);
   assign hit2 = hz.UsesSrc2_IFID & (hz.DstReg1_in_from_IDEX == hz.SrcReg2_in_from_IFID)
                 & (|hz.DstReg1_in_from_IDEX);

   // Store data is forwarded MEM-to-MEM, so a Src1 hit on a store is not a load-use hazard.
   assign load_use = hz.MemRead_IDEX & ((hit1 & ~hz.MemWrite_IFID) | hit2);
   assign br_hz    = hz.BR_IFID & hz.RegWrite_IDEX & hit1;
   assign flag_hz  = hz.Branch_IFID & hz.FlagWrite_IDEX;

   always_comb begin
      n_stall = 2'd0;
      if (br_hz && hz.MemRead_IDEX)
         n_stall = 2'd2;
      else if (br_hz || load_use || flag_hz)
         n_stall = 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         rem       <= 2'd0;
         saved_rem <= 2'd0;
      end else begin
         state     <= state_nx;
         rem       <= rem_nx;
         saved_rem <= saved_rem_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      rem_nx          = rem;
      saved_rem_nx    = saved_rem;
      eff_rem         = (state == MEM_WAIT) ? saved_rem : rem;
      hz.PC_write     = 1'b1;
      hz.IFID_write   = 1'b1;
      hz.IDEX_bubble  = 1'b0;
      hz.IFID_flush   = 1'b0;
      hz.pipe_hold    = 1'b0;
      hz.MEMWB_bubble = 1'b0;
      if (rst) begin
         state_nx = RUN;
      end else if (hz.mem_busy) begin
         state_nx        = MEM_WAIT;
         if (state != MEM_WAIT)
            saved_rem_nx = rem;
         hz.PC_write     = 1'b0;
         hz.IFID_write   = 1'b0;
         hz.pipe_hold    = 1'b1;
         hz.MEMWB_bubble = 1'b1;
      end else if (state == STALL || (state == MEM_WAIT && saved_rem != 2'd0)) begin
         // Leaving MEM_WAIT with owed cycles behaves exactly like a STALL cycle.
         hz.PC_write    = 1'b0;
         hz.IFID_write  = 1'b0;
         hz.IDEX_bubble = 1'b1;
         rem_nx         = eff_rem - 2'd1;
         saved_rem_nx   = 2'd0;
         state_nx       = (eff_rem > 2'd1) ? STALL : RUN;
      end else begin
         rem_nx       = 2'd0;
         saved_rem_nx = 2'd0;
         state_nx     = RUN;
         if (n_stall != 2'd0) begin
            hz.PC_write    = 1'b0;
            hz.IFID_write  = 1'b0;
            hz.IDEX_bubble = 1'b1;
            if (n_stall == 2'd2) begin
               rem_nx   = 2'd1;
               state_nx = STALL;
            end
         end else begin
            hz.IFID_flush = hz.branch_taken_ID;
         end
      end
   end

`ifdef STALL_CNT_EN
   logic [15:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 16'd0;
      else if (!hz.PC_write && cnt != 16'hFFFF)
         cnt <= cnt + 16'd1;
   end

   assign hz.stall_cycles = cnt;
`else
   assign hz.stall_cycles = 16'd0;
`endif

endmodule
